rotate_arbiter: RTL and testbench

- Shares one combinational rotate datapath (WIDTH-bit left rotate by i_amt) between NUM_REQ requesters.
- Arbitrates with fair round-robin, converts per-request direction/amount into a left-rotate amount, and registers the result into a single-entry output stage.
- Sits between several bit-manipulation clients and one rotate instance, so area is paid once.

---
 rtl/rotate_arbiter_pkg.sv | 29 ++
 rtl/rotate_arbiter_rr.sv | 32 +++
 rtl/rotate_arbiter.sv | 108 ++++++++++
 tb/tb_rotate_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_arbiter_pkg.sv
// Shared types and amount arithmetic for the round-robin rotate arbiter.
// Module-level widths are derived from each instance's own parameters.
package rotate_arbiter_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_AMT_W   = $clog2(DEF_WIDTH);
    localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    // A right rotate by a is a left rotate by (width - a) mod width.
    function automatic int unsigned eff_amt(
        input int unsigned amt,
        input logic        dir,
        input int unsigned width
    );
        int unsigned a;
        a = amt % width;
        if (dir) begin
            return (width - a) % width;
        end
        return a;
    endfunction

endpackage

// File: rtl/rotate_arbiter_rr.sv
// Round-robin grant search starting at a pointer and wrapping.
// Produces a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W-1:0] sel;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_en && !o_any && i_req[sel]) begin
                o_gnt[sel] = 1'b1;
                o_idx      = sel;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one left-rotate datapath among requesters,
// with a single-entry registered result stage.
module rotate_arbiter
    import rotate_arbiter_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_REQ = 4,
    localparam int AMT_W   = $clog2(WIDTH),
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_data,
    input  logic [NUM_REQ*AMT_W-1:0] i_amt,
    input  logic [NUM_REQ-1:0]       i_dir,
    output logic [NUM_REQ-1:0]       o_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [ID_W-1:0]          o_id,
    input  logic                     i_ready
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic               can_accept;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    logic [WIDTH-1:0]   sel_data;
    logic [AMT_W-1:0]   sel_amt;
    logic               sel_dir;
    logic [AMT_W-1:0]   rot_amt;
    logic [2*WIDTH-1:0] rot_dbl;
    logic [WIDTH-1:0]   rot_data;

    assign can_accept = (state_q == S_EMPTY) || i_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req (i_valid),
        .i_ptr (ptr_q),
        .i_en  (can_accept && !i_reset),
        .o_gnt (gnt),
        .o_idx (gnt_idx),
        .o_any (gnt_any)
    );

    always_comb begin
        sel_data = '0;
        sel_amt  = '0;
        sel_dir  = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (gnt[n]) begin
                sel_data = i_data[n*WIDTH +: WIDTH];
                sel_amt  = i_amt[n*AMT_W +: AMT_W];
                sel_dir  = i_dir[n];
            end
        end
    end

    // Single shared rotator: upper half of the doubled word after a left shift.
    always_comb begin
        rot_amt  = AMT_W'(eff_amt(32'(sel_amt), sel_dir, unsigned'(WIDTH)));
        rot_dbl  = {sel_data, sel_data} << rot_amt;
        rot_data = rot_dbl[2*WIDTH-1 -: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (gnt_any) begin
            state_d = S_FULL;
            data_d  = rot_data;
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == S_FULL && i_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_ready = gnt;
    assign o_valid = (state_q == S_FULL);
    assign o_data  = data_q;
    assign o_id    = id_q;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Randomized and directed check of rotate_arbiter against a behavioural
// round-robin / rotate reference model.
module tb_rotate_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  valid;
    logic [W-1:0]  data [N];
    logic [AW-1:0] amt  [N];
    logic [N-1:0]  dir;
    logic          rdy;
    logic [N-1:0]  o_ready;
    logic          o_valid;
    logic [W-1:0]  o_data;
    logic [IW-1:0] o_id;

    logic [N*W-1:0]  data_flat;
    logic [N*AW-1:0] amt_flat;

    logic          rst5;
    logic [1:0]    valid5;
    logic [9:0]    data5;
    logic [5:0]    amt5;
    logic [1:0]    dir5;
    logic          rdy5;
    logic [1:0]    o_ready5;
    logic          o_valid5;
    logic [4:0]    o_data5;
    logic          o_id5;

    int n_chk  = 0;
    int n_fail = 0;

    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    int           m_ptr;

    always #5 clk = ~clk;

    always_comb begin
        for (int n = 0; n < N; n++) begin
            data_flat[n*W +: W]  = data[n];
            amt_flat[n*AW +: AW] = amt[n];
        end
    end

    rotate_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_valid (valid),
        .i_data  (data_flat),
        .i_amt   (amt_flat),
        .i_dir   (dir),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_id    (o_id),
        .i_ready (rdy)
    );

    rotate_arbiter #(.WIDTH(5), .NUM_REQ(2)) dut5 (
        .i_clock (clk),
        .i_reset (rst5),
        .i_valid (valid5),
        .i_data  (data5),
        .i_amt   (amt5),
        .i_dir   (dir5),
        .o_ready (o_ready5),
        .o_valid (o_valid5),
        .o_data  (o_data5),
        .o_id    (o_id5),
        .i_ready (rdy5)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-placement rotate: left moves bit i to i+a, right moves it to i-a.
    function automatic logic [W-1:0] rot_ref(input logic [W-1:0] d,
                                             input int a0, input bit right);
        logic [W-1:0] r;
        int a;
        a = a0 % W;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (!right) r[(i + a) % W] = d[i];
            else        r[(i - a + W) % W] = d[i];
        end
        return r;
    endfunction

    // One clock: check against the model mid-cycle, then advance the model.
    task automatic cyc();
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        g = -1;
        if (!rst && (!m_valid || rdy)) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("o_ready", 32'(o_ready), 32'(exp_rdy));
        check("o_valid", 32'(o_valid), 32'(m_valid));
        if (m_valid) begin
            check("o_data", 32'(o_data), 32'(m_data));
            check("o_id", 32'(o_id), 32'(m_id));
        end
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = rot_ref(data[g], int'(amt[g]), dir[g]);
            m_id    = g;
            m_ptr   = (g + 1) % N;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int n, input logic [W-1:0] d,
                       input int a, input bit r);
        valid    = '0;
        valid[n] = 1'b1;
        data[n]  = d;
        amt[n]   = AW'(a);
        dir[n]   = r;
    endtask

    initial begin
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
        rst = 1'b1;
        rdy = 1'b1;
        valid = '1;
        dir = '0;
        for (int n = 0; n < N; n++) begin
            data[n] = 8'(n * 17 + 3);
            amt[n]  = AW'(n);
        end
        rst5 = 1'b1; valid5 = '0; data5 = '0; amt5 = '0; dir5 = '0; rdy5 = 1'b1;

        repeat (3) cyc();
        check("reset_data", 32'(o_data), 32'h0);

        rst = 1'b0;
        cyc();
        check("first_grant_id", 32'(o_id), 32'd0);
        valid = '0;
        cyc();

        req(1, 8'hB4, 3, 1'b0);
        cyc();
        check("rotl_data", 32'(o_data), 32'hA5);
        check("rotl_id", 32'(o_id), 32'd1);

        req(2, 8'h81, 1, 1'b1);
        cyc();
        check("rotr_data", 32'(o_data), 32'hC0);
        req(2, 8'h5A, 0, 1'b1);
        cyc();
        check("amt0_data", 32'(o_data), 32'h5A);

        req(3, 8'h11, 1, 1'b0);
        cyc();
        valid = '1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("rr_valid", 32'(o_valid), 32'd1);
            check("rr_id", 32'(o_id), 32'(k % 4));
        end

        req(3, 8'h0F, 2, 1'b0);
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            data[3] = 8'(data[3] + 8'h10);
            cyc();
            check("stall_id", 32'(o_id), 32'd3);
            check("stall_ready", 32'(o_ready), 32'd0);
        end
        data[3] = 8'h21;
        rdy = 1'b1;
        cyc();
        check("bp_release_data", 32'(o_data), 32'h84);
        valid = '0;
        cyc();

        for (int t = 0; t < 400; t++) begin
            rst = ($urandom_range(0, 49) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            valid = N'($urandom);
            dir = N'($urandom);
            for (int n = 0; n < N; n++) begin
                data[n] = W'($urandom);
                amt[n]  = AW'($urandom);
            end
            cyc();
        end
        rst = 1'b0;

        @(negedge clk);
        rst5 = 1'b0;
        valid5 = 2'b01;
        data5[4:0] = 5'b00011;
        amt5[2:0] = 3'd7;
        dir5 = 2'b00;
        @(posedge clk);
        #1;
        valid5 = '0;
        rdy5 = 1'b0;
        check("w5_valid", 32'(o_valid5), 32'd1);
        check("w5_data", 32'(o_data5), 32'h0C);
        check("w5_id", 32'(o_id5), 32'd0);
        rst5 = 1'b1;
        @(posedge clk);
        #1;
        check("w5_reset_valid", 32'(o_valid5), 32'd0);
        check("w5_reset_ready", 32'(o_ready5), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
